complete_arbiter: RTL and testbench

Shares the two ROB complete/writeback ports between four result producers: ALU0, ALU1, ALU2 and the LSU/data-memory return path. Sits between the functional units and the reorder buffer's complete_pc/new_dr_data inputs. Each source gets a one-entry holding buffer. A round-robin scheduler grants up to two buffered results per cycle onto registered complete ports.

---
 rtl/complete_arbiter.sv | 155 +++++++++++++++
 tb/tb_complete_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/complete_arbiter.sv
// Round-robin arbiter folding four result producers (ALU0-2, LSU) onto two registered ROB complete ports.
// Optional COMPLETE_ARB_STATS_EN adds saturating conflict/block counters.

module complete_arb_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         grant,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] dout
);
  // A load in the same cycle as a grant replaces the departing entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (grant) begin
      valid <= 1'b0;
    end
  end
endmodule

module complete_arbiter #(
  parameter int DATA_W = 32,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          src_valid,
  output logic [3:0]          src_ready,
  input  logic [4*DATA_W-1:0] src_pc,
  input  logic [4*DATA_W-1:0] src_data,
  input  logic [4*PREG_W-1:0] src_preg,
  input  logic [4*ROB_W-1:0]  src_rob,
  input  logic [3:0]          src_is_store,
  input  logic                cmp_ready,
  output logic                cmp0_valid,
  output logic [DATA_W-1:0]   cmp0_pc,
  output logic [DATA_W-1:0]   cmp0_data,
  output logic [PREG_W-1:0]   cmp0_preg,
  output logic [ROB_W-1:0]    cmp0_rob,
  output logic                cmp0_is_store,
  output logic                cmp1_valid,
  output logic [DATA_W-1:0]   cmp1_pc,
  output logic [DATA_W-1:0]   cmp1_data,
  output logic [PREG_W-1:0]   cmp1_preg,
  output logic [ROB_W-1:0]    cmp1_rob,
  output logic                cmp1_is_store
`ifdef COMPLETE_ARB_STATS_EN
  ,
  output logic [15:0]         stat_conflict_cnt,
  output logic [15:0]         stat_block_cnt
`endif
);
  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] data;
    logic [PREG_W-1:0] preg;
    logic [ROB_W-1:0]  rob;
    logic              is_store;
  } ent_t;

  ent_t [3:0] src_ent, buf_ent;
  logic [3:0] buf_valid, grant;
  logic [1:0] rr_ptr, idx, g0_idx, g1_idx, last_idx;
  logic       g0_vld, g1_vld;
  ent_t       cmp0_q, cmp1_q;

  assign src_ready = ~buf_valid | grant;

  for (genvar i = 0; i < 4; i++) begin : g_src
    assign src_ent[i] = {src_pc[i*DATA_W +: DATA_W], src_data[i*DATA_W +: DATA_W],
                         src_preg[i*PREG_W +: PREG_W], src_rob[i*ROB_W +: ROB_W],
                         src_is_store[i]};
    complete_arb_buf #(.W($bits(ent_t))) u_buf (
      .clk   (clk),
      .rst   (rst),
      .load  (src_valid[i] & src_ready[i]),
      .grant (grant[i]),
      .din   (src_ent[i]),
      .valid (buf_valid[i]),
      .dout  (buf_ent[i])
    );
  end

  // First two buffered sources found scanning from rr_ptr win ports 0 and 1.
  always_comb begin
    grant  = '0;
    g0_vld = 1'b0;
    g1_vld = 1'b0;
    g0_idx = '0;
    g1_idx = '0;
    idx    = '0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (cmp_ready && buf_valid[idx]) begin
        if (!g0_vld) begin
          g0_vld = 1'b1;
          g0_idx = idx;
        end else if (!g1_vld) begin
          g1_vld = 1'b1;
          g1_idx = idx;
        end
      end
    end
    if (g0_vld) grant[g0_idx] = 1'b1;
    if (g1_vld) grant[g1_idx] = 1'b1;
  end

  assign last_idx = g1_vld ? g1_idx : g0_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      cmp0_valid <= 1'b0;
      cmp1_valid <= 1'b0;
      cmp0_q     <= '0;
      cmp1_q     <= '0;
    end else begin
      cmp0_valid <= g0_vld;
      cmp1_valid <= g1_vld;
      if (g0_vld) begin
        rr_ptr <= last_idx + 2'd1;
        cmp0_q <= buf_ent[g0_idx];
      end
      if (g1_vld) cmp1_q <= buf_ent[g1_idx];
    end
  end

  assign {cmp0_pc, cmp0_data, cmp0_preg, cmp0_rob, cmp0_is_store} = cmp0_q;
  assign {cmp1_pc, cmp1_data, cmp1_preg, cmp1_rob, cmp1_is_store} = cmp1_q;

`ifdef COMPLETE_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_conflict_cnt <= '0;
      stat_block_cnt    <= '0;
    end else begin
      if (cmp_ready && ($countones(buf_valid) > 2) && stat_conflict_cnt != 16'hFFFF)
        stat_conflict_cnt <= stat_conflict_cnt + 16'd1;
      if (!cmp_ready && (|buf_valid) && stat_block_cnt != 16'hFFFF)
        stat_block_cnt <= stat_block_cnt + 16'd1;
    end
  end
`else
  // statistics counters compiled out
`endif
endmodule

// File: tb/tb_complete_arbiter.sv
// Randomized bench for complete_arbiter against a queue-based round-robin reference model.
// Also exercises directed single-beat and four-way simultaneous cases.
module tb_complete_arbiter;
  localparam int DW = 32, PW = 6, RW = 4;

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] data;
    logic [PW-1:0] preg;
    logic [RW-1:0] rob;
    logic          st;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      src_valid, src_ready, src_is_store;
  logic [4*DW-1:0] src_pc, src_data;
  logic [4*PW-1:0] src_preg;
  logic [4*RW-1:0] src_rob;
  logic            cmp_ready;
  logic            cmp0_valid, cmp1_valid, cmp0_is_store, cmp1_is_store;
  logic [DW-1:0]   cmp0_pc, cmp0_data, cmp1_pc, cmp1_data;
  logic [PW-1:0]   cmp0_preg, cmp1_preg;
  logic [RW-1:0]   cmp0_rob, cmp1_rob;
`ifdef COMPLETE_ARB_STATS_EN
  logic [15:0]     stat_conflict_cnt, stat_block_cnt;
`endif

  always #5 clk = ~clk;

  logic [3:0] sv;
  ent_t       se [4];

  assign src_valid = sv;
  for (genvar i = 0; i < 4; i++) begin : g_drv
    assign src_pc[i*DW +: DW]   = se[i].pc;
    assign src_data[i*DW +: DW] = se[i].data;
    assign src_preg[i*PW +: PW] = se[i].preg;
    assign src_rob[i*RW +: RW]  = se[i].rob;
    assign src_is_store[i]      = se[i].st;
  end

  complete_arbiter #(.DATA_W(DW), .PREG_W(PW), .ROB_W(RW)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_pc(src_pc), .src_data(src_data), .src_preg(src_preg),
    .src_rob(src_rob), .src_is_store(src_is_store),
    .cmp_ready(cmp_ready),
    .cmp0_valid(cmp0_valid), .cmp0_pc(cmp0_pc), .cmp0_data(cmp0_data),
    .cmp0_preg(cmp0_preg), .cmp0_rob(cmp0_rob), .cmp0_is_store(cmp0_is_store),
    .cmp1_valid(cmp1_valid), .cmp1_pc(cmp1_pc), .cmp1_data(cmp1_data),
    .cmp1_preg(cmp1_preg), .cmp1_rob(cmp1_rob), .cmp1_is_store(cmp1_is_store)
`ifdef COMPLETE_ARB_STATS_EN
    ,
    .stat_conflict_cnt(stat_conflict_cnt), .stat_block_cnt(stat_block_cnt)
`endif
  );

  // reference model state
  logic [3:0] m_v;
  ent_t       m_e [4];
  int         rr;
  logic       e_v0, e_v1;
  ent_t       e_e0, e_e1;
  logic [3:0] acc;
  int         s_conf, s_blk;
  int         n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: check DUT against model at negedge, advance model, return 1ns after posedge.
  task automatic cyc(input bit chk_on);
    int order[$];
    int g0, g1;
    logic [3:0] gr, rdy;
    @(negedge clk);
    g0 = -1;
    g1 = -1;
    for (int k = 0; k < 4; k++)
      if (m_v[(rr + k) % 4]) order.push_back((rr + k) % 4);
    if (cmp_ready) begin
      if (order.size() > 0) g0 = order[0];
      if (order.size() > 1) g1 = order[1];
    end
    gr = '0;
    if (g0 >= 0) gr[g0] = 1'b1;
    if (g1 >= 0) gr[g1] = 1'b1;
    rdy = ~m_v | gr;
    if (chk_on) begin
      if (!rst) chk("src_ready", 128'(src_ready), 128'(rdy));
      chk("cmp0_valid", 128'(cmp0_valid), 128'(e_v0));
      chk("cmp1_valid", 128'(cmp1_valid), 128'(e_v1));
      chk("cmp0_ent", 128'({cmp0_pc, cmp0_data, cmp0_preg, cmp0_rob, cmp0_is_store}), 128'(e_e0));
      chk("cmp1_ent", 128'({cmp1_pc, cmp1_data, cmp1_preg, cmp1_rob, cmp1_is_store}), 128'(e_e1));
`ifdef COMPLETE_ARB_STATS_EN
      chk("stat_conflict", 128'(stat_conflict_cnt), 128'(s_conf));
      chk("stat_block", 128'(stat_block_cnt), 128'(s_blk));
`endif
    end
    if (rst) begin
      m_v = '0; rr = 0; e_v0 = 0; e_v1 = 0; e_e0 = '0; e_e1 = '0;
      acc = '0; s_conf = 0; s_blk = 0;
      for (int i = 0; i < 4; i++) m_e[i] = '0;
    end else begin
      if (cmp_ready && order.size() > 2 && s_conf < 65535) s_conf++;
      if (!cmp_ready && order.size() > 0 && s_blk < 65535) s_blk++;
      e_v0 = (g0 >= 0);
      e_v1 = (g1 >= 0);
      if (g0 >= 0) begin
        e_e0 = m_e[g0];
        rr = (((g1 >= 0) ? g1 : g0) + 1) % 4;
      end
      if (g1 >= 0) e_e1 = m_e[g1];
      for (int i = 0; i < 4; i++) begin
        acc[i] = sv[i] && rdy[i];
        if (acc[i]) begin
          m_v[i] = 1'b1;
          m_e[i] = se[i];
        end else if (gr[i]) m_v[i] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ent(input int i);
    se[i].pc   = $urandom;
    se[i].data = $urandom;
    se[i].preg = PW'($urandom);
    se[i].rob  = RW'($urandom);
    se[i].st   = 1'($urandom);
  endtask

  initial begin
    rst = 1'b1; sv = '0; cmp_ready = 1'b0;
    for (int i = 0; i < 4; i++) se[i] = '0;
    cyc(0);
    rst = 1'b0;
    cyc(1);

    // single beat from ALU1
    cmp_ready = 1'b1;
    sv = 4'b0010;
    se[1] = '{pc: 32'h40, data: 32'h1234, preg: 6'd5, rob: 4'd3, st: 1'b0};
    cyc(1);
    sv = '0;
    cyc(1);
    chk("single_v0", 128'(cmp0_valid), 128'(1));
    chk("single_v1", 128'(cmp1_valid), 128'(0));
    chk("single_pc", 128'(cmp0_pc), 128'(32'h40));
    chk("single_data", 128'(cmp0_data), 128'(32'h1234));
    chk("single_preg_rob", 128'({cmp0_preg, cmp0_rob}), 128'({6'd5, 4'd3}));

    // four simultaneous from a fresh reset
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("rst_ready", 128'(src_ready), 128'(4'hF));
    chk("rst_valids", 128'({cmp0_valid, cmp1_valid}), 128'(0));
    sv = 4'hF;
    for (int i = 0; i < 4; i++) begin
      rand_ent(i);
      se[i].pc = 32'h100 + 32'(i);
    end
    cyc(1);
    sv = '0;
    cyc(1);
    chk("four_a_pc", 128'({cmp0_pc, cmp1_pc}), 128'({32'h100, 32'h101}));
    cyc(1);
    chk("four_b_pc", 128'({cmp0_pc, cmp1_pc}), 128'({32'h102, 32'h103}));
    chk("four_b_v", 128'({cmp0_valid, cmp1_valid}), 128'(2'b11));
    cyc(1);

    // randomized traffic; unaccepted sources hold valid and payload
    acc = '0;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      cmp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        if (!(sv[i] && !acc[i])) begin
          sv[i] = ($urandom_range(0, 9) < 6);
          rand_ent(i);
        end
      end
      cyc(1);
    end
    rst = 1'b0; sv = '0; cmp_ready = 1'b1;
    cyc(1);
    cyc(1);
    cyc(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
